// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: entry field widths, source ids and entry sizing.
// An entry is packed as {instr, warp_id, dst, lane_data} with lane data in the low bits.
package cdb_arbiter_pkg;

    localparam int INSTR_W = 32;
    localparam int WARP_W  = 3;
    localparam int DST_W   = 5;
    localparam int HDR_W   = INSTR_W + WARP_W + DST_W;

    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_MULT = 1'b1
    } src_e;

    function automatic int entry_w(input int lane_w);
        return HDR_W + lane_w;
    endfunction

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MULT : SRC_ALU;
    endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result FIFO: push/pop with registered storage, pointers and occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module cdb_src_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("cdb_src_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Guards here keep the FIFO self-consistent even if a caller ignores full/empty.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: queues ALU and MULT writebacks in per-source FIFOs and broadcasts
// one result per cycle on a registered CDB, choosing between sources round-robin on contention.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_THREADS = 8,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic                              Valid_ALU_CDB,
    input  logic [INSTR_W-1:0]                Instr_ALU_CDB,
    input  logic [WARP_W-1:0]                 WarpID_ALU_CDB,
    input  logic                              RegWrite_ALU_CDB,
    input  logic [DST_W-1:0]                  Dst_ALU_CDB,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_ALU_CDB,

    input  logic                              Valid_MULT_CDB,
    input  logic [INSTR_W-1:0]                Instr_MULT_CDB,
    input  logic [WARP_W-1:0]                 WarpID_MULT_CDB,
    input  logic                              RegWrite_MULT_CDB,
    input  logic [DST_W-1:0]                  Dst_MULT_CDB,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_MULT_CDB,

    output logic                              Stall_CDB_ALU,
    output logic                              Stall_CDB_MULT,

    output logic                              Valid_CDB,
    output logic [INSTR_W-1:0]                Instr_CDB,
    output logic [WARP_W-1:0]                 WarpID_CDB,
    output logic                              RegWrite_CDB,
    output logic [DST_W-1:0]                  Dst_CDB,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_CDB
);

    localparam int LANE_W    = NUM_THREADS * DATA_WIDTH;
    localparam int ENTRY_W   = entry_w(LANE_W);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int DATA_LSB  = 0;
    localparam int DST_LSB   = DATA_LSB + LANE_W;
    localparam int WARP_LSB  = DST_LSB + DST_W;
    localparam int INSTR_LSB = WARP_LSB + WARP_W;

    logic [ENTRY_W-1:0] alu_entry, mult_entry;
    logic [ENTRY_W-1:0] alu_head, mult_head, head_sel;
    logic               alu_push, mult_push;
    logic               alu_pop, mult_pop;
    logic               alu_full, mult_full;
    logic               alu_empty, mult_empty;
    logic [CNT_W-1:0]   alu_count, mult_count;

    src_e               rr_q, rr_d;
    src_e               grant;
    logic               grant_valid;
    logic               tie;

    logic               valid_q;
    logic [ENTRY_W-1:0] entry_q;

    assign alu_entry  = {Instr_ALU_CDB, WarpID_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB};
    assign mult_entry = {Instr_MULT_CDB, WarpID_MULT_CDB, Dst_MULT_CDB, Dst_Data_MULT_CDB};

    // Branches (RegWrite=0) never occupy a FIFO slot; a push into a full FIFO is dropped.
    assign alu_push  = Valid_ALU_CDB && RegWrite_ALU_CDB && !alu_full;
    assign mult_push = Valid_MULT_CDB && RegWrite_MULT_CDB && !mult_full;

    cdb_src_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (alu_push),
        .data_i  (alu_entry),
        .pop_i   (alu_pop),
        .data_o  (alu_head),
        .full_o  (alu_full),
        .empty_o (alu_empty),
        .count_o (alu_count)
    );

    cdb_src_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_mult_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (mult_push),
        .data_i  (mult_entry),
        .pop_i   (mult_pop),
        .data_o  (mult_head),
        .full_o  (mult_full),
        .empty_o (mult_empty),
        .count_o (mult_count)
    );

    // Pointer only moves after a contended grant, so a lone source never steals the next tie.
    always_comb begin
        tie         = !alu_empty && !mult_empty;
        grant_valid = !alu_empty || !mult_empty;
        grant       = SRC_ALU;
        rr_d        = rr_q;
        if (tie) begin
            grant = rr_q;
            rr_d  = other_src(rr_q);
        end else if (alu_empty) begin
            grant = SRC_MULT;
        end
    end

    assign alu_pop  = grant_valid && (grant == SRC_ALU);
    assign mult_pop = grant_valid && (grant == SRC_MULT);
    assign head_sel = (grant == SRC_ALU) ? alu_head : mult_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= SRC_ALU;
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            rr_q    <= rr_d;
            valid_q <= grant_valid;
            if (grant_valid) begin
                entry_q <= head_sel;
            end
        end
    end

    // Stall comes from registered occupancy only; a pop in the same cycle does not release it.
    assign Stall_CDB_ALU  = (alu_count == CNT_W'(FIFO_DEPTH));
    assign Stall_CDB_MULT = (mult_count == CNT_W'(FIFO_DEPTH));

    assign Valid_CDB    = valid_q;
    assign RegWrite_CDB = valid_q;
    assign Instr_CDB    = entry_q[INSTR_LSB +: INSTR_W];
    assign WarpID_CDB   = entry_q[WARP_LSB +: WARP_W];
    assign Dst_CDB      = entry_q[DST_LSB +: DST_W];
    assign Dst_Data_CDB = entry_q[DATA_LSB +: LANE_W];

    a_alu_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(Valid_ALU_CDB && RegWrite_ALU_CDB && alu_full))
        else $error("cdb_arbiter: ALU result pushed while ALU FIFO full, entry dropped");

    a_mult_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(Valid_MULT_CDB && RegWrite_MULT_CDB && mult_full))
        else $error("cdb_arbiter: MULT result pushed while MULT FIFO full, entry dropped");

endmodule
